snake_tick_input_ctrl: RTL and testbench

//  Upstream timing/input stage for snake_game_fsm. Divides the per-frame pulse frame_tik into game_tik.
//  The division ratio shrinks as the score rises, so the snake speeds up.

---
 rtl/snake_tick_input_ctrl.sv | 146 ++++++++++++++
 tb/tb_snake_tick_input_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/snake_tick_input_ctrl.sv
// snake_tick_input_ctrl
//   Timing and input stage in front of snake_game_fsm.
//   - Divides frame_tik into game_tik. The divisor shrinks as the score rises.
//   - Synchronises and debounces the two raw active-low buttons.
//   - Latches one turn command per tick interval.
//   - Presents that command on right_P/left_P (active-low) for the whole following interval.
//
// Ports
//   clock_25   in   system clock
//   reset      in   asynchronous active-low reset
//   frame_tik  in   one-cycle pulse per video frame
//   score      in   [7:0] current score
//   right_btn  in   raw right button (active-low, asynchronous)
//   left_btn   in   raw left button  (active-low, asynchronous)
//   game_tik   out  one-cycle game step pulse
//   right_P    out  latched right command (active-low)
//   left_P     out  latched left command  (active-low)
//   tick_div   out  [DIV_W-1:0] divisor currently in use
//
// Configuration macro: SNAKE_TICK_SPEEDUP_EN
//   Defined:   the divisor follows the score.
//   Undefined: the divisor is constant at BASE_DIV, and score is ignored.

// Per-button synchroniser and debouncer.
// press is a one-cycle strobe on the cycle whose edge moves the debounced level from 1 to 0.
module snake_btn_db #(
  parameter int CYC  = 250000,
  parameter int DB_W = 18
) (
  input  logic clock_25,
  input  logic reset,
  input  logic btn,
  output logic press
);
  logic            s1, s2, lvl;
  logic [DB_W-1:0] cnt;
  logic            hit;

  // The counter runs only while the synchronised level disagrees with the debounced level.
  // Any return to agreement restarts it, so short glitches are dropped.
  assign hit   = (s2 != lvl) && (cnt == DB_W'(CYC - 1));
  assign press = hit && lvl;

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      s1  <= 1'b1;
      s2  <= 1'b1;
      lvl <= 1'b1;
      cnt <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (hit) begin
        lvl <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module snake_tick_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DB_W            = 18,
  parameter int BASE_DIV        = 6,
  parameter int MIN_DIV         = 2,
  parameter int SPEED_SHIFT     = 2,
  parameter int DIV_W           = 4
) (
  input  logic             clock_25,
  input  logic             reset,
  input  logic             frame_tik,
  input  logic [7:0]       score,
  input  logic             right_btn,
  input  logic             left_btn,
  output logic             game_tik,
  output logic             right_P,
  output logic             left_P,
  output logic [DIV_W-1:0] tick_div
);
  localparam int NUM_BTN = 2;  // bit 0 = right, bit 1 = left

  logic [NUM_BTN-1:0] btn_raw, press;
  logic [DIV_W-1:0]   fcnt, next_div;
  logic               pend_r, pend_l, upd, take;
  logic               one_r, one_l;

  assign btn_raw = {left_btn, right_btn};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    snake_btn_db #(.CYC(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db (
      .clock_25 (clock_25),
      .reset    (reset),
      .btn      (btn_raw[g]),
      .press    (press[g])
    );
  end

`ifdef SNAKE_TICK_SPEEDUP_EN
  logic [7:0] sub;
  assign sub      = score >> SPEED_SHIFT;
  assign next_div = (sub >= 8'(BASE_DIV - MIN_DIV)) ? DIV_W'(MIN_DIV)
                                                     : DIV_W'(BASE_DIV) - DIV_W'(sub);
`else
  logic unused_score;
  assign unused_score = ^score;
  assign next_div     = DIV_W'(BASE_DIV);
`endif

  assign upd = frame_tik && (fcnt == tick_div - DIV_W'(1));

  // Simultaneous right and left strobes are ambiguous, so they cancel each other.
  assign one_r = press[0] & ~press[1];
  assign one_l = press[1] & ~press[0];

  // On an update edge the pending set is cleared and reloaded in the same edge.
  // A strobe arriving on that edge therefore seeds the next interval.
  assign take = upd | ~(pend_r | pend_l);

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      fcnt     <= '0;
      game_tik <= 1'b0;
      right_P  <= 1'b1;
      left_P   <= 1'b1;
      tick_div <= DIV_W'(BASE_DIV);
      pend_r   <= 1'b0;
      pend_l   <= 1'b0;
    end else begin
      game_tik <= upd;
      if (frame_tik) fcnt <= upd ? '0 : fcnt + 1'b1;
      if (upd) begin
        right_P  <= ~pend_r;
        left_P   <= ~pend_l;
        tick_div <= next_div;
      end
      if (take) begin
        pend_r <= one_r;
        pend_l <= one_l;
      end
    end
  end
endmodule

// File: tb/tb_snake_tick_input_ctrl.sv
module tb_snake_tick_input_ctrl;
  localparam int DIV_W = 4;

  logic             clock_25 = 1'b0;
  logic             reset = 1'b0;
  logic             frame_tik = 1'b0;
  logic [7:0]       score = 8'd0;
  logic             right_btn = 1'b1;
  logic             left_btn = 1'b1;
  logic             game_tik, right_P, left_P;
  logic [DIV_W-1:0] tick_div;

  snake_tick_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clock_25  (clock_25),
    .reset     (reset),
    .frame_tik (frame_tik),
    .score     (score),
    .right_btn (right_btn),
    .left_btn  (left_btn),
    .game_tik  (game_tik),
    .right_P   (right_P),
    .left_P    (left_P),
    .tick_div  (tick_div)
  );

  always #20 clock_25 = ~clock_25;

  typedef struct { int cyc; int rp; int lp; int div; } exp_t;
  exp_t q[$];
  exp_t e;
  int   n_chk = 0, n_pass = 0, cyc = 0, cur_div = 6, prev_rp = 1, prev_lp = 1;
  logic gt_prev = 1'b0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
  endtask

  function automatic int calc_div(input int s);
`ifdef SNAKE_TICK_SPEEDUP_EN
    int sub;
    sub = s >> 2;
    return (sub >= 4) ? 2 : 6 - sub;
`else
    return 6 + (s & 0);
`endif
  endfunction

  always @(posedge clock_25) cyc <= cyc + 1;

  // Each game_tik pops the expected outputs and the expected cycle from the scoreboard.
  always @(negedge clock_25) begin
    if (reset && game_tik) begin
      chk("tik_consec", int'(gt_prev), 0);
      if (q.size() == 0) begin
        chk("unexp_tik", 1, 0);
      end else begin
        e = q.pop_front();
        chk("tik_cyc", cyc, e.cyc);
        chk("tik_rp", int'(right_P), e.rp);
        chk("tik_lp", int'(left_P), e.lp);
        chk("tik_div", int'(tick_div), e.div);
      end
    end
    gt_prev <= game_tik;
  end

  task automatic tick;
    @(posedge clock_25);
    #1;
  endtask

  task automatic frame(input bit last, input int rp, input int lp);
    frame_tik = 1'b1;
    if (last) begin
      q.push_back('{cyc + 1, rp, lp, calc_div(score)});
      cur_div = calc_div(score);
      prev_rp = rp;
      prev_lp = lp;
    end
    tick;
    frame_tik = 1'b0;
    tick;
    tick;
  endtask

  // One full interval. Partway through, the outputs must still hold what the previous tick
  // applied. At the end, the expected tick must have been consumed.
  task automatic interval(input int rp, input int lp);
    int n;
    n = cur_div;
    for (int i = 0; i < n; i++) begin
      if (i == n / 2) begin
        chk("hold_rp", int'(right_P), prev_rp);
        chk("hold_lp", int'(left_P), prev_lp);
      end
      frame(i == n - 1, rp, lp);
    end
    tick;
    chk("q_drain", q.size(), 0);
  endtask

  task automatic press(input bit r, input bit l, input int n);
    right_btn = ~r;
    left_btn  = ~l;
    repeat (n) tick;
    right_btn = 1'b1;
    left_btn  = 1'b1;
    repeat (10) tick;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick;
    chk("rst_tik", int'(game_tik), 0);
    chk("rst_rp", int'(right_P), 1);
    chk("rst_lp", int'(left_P), 1);
    chk("rst_div", int'(tick_div), 6);
    reset = 1'b1;
    tick;

    // Score 0: two intervals of six frames each.
    interval(1, 1);
    interval(1, 1);

    // A short glitch gives no press. A long hold gives right_P=0 for one interval.
    press(1'b1, 1'b0, 3);
    interval(1, 1);
    press(1'b1, 1'b0, 12);
    interval(0, 1);
    interval(1, 1);

    // The first command in an interval wins. Simultaneous presses cancel.
    press(1'b0, 1'b1, 10);
    press(1'b1, 1'b0, 10);
    interval(1, 0);
    press(1'b1, 1'b1, 10);
    interval(1, 1);
    interval(1, 1);

    // A press strobe on the update edge lands in the following interval.
    for (int i = 0; i < cur_div - 1; i++) frame(1'b0, 1, 1);
    right_btn = 1'b0;
    repeat (5) tick;
    frame_tik = 1'b1;
    q.push_back('{cyc + 1, 1, 1, calc_div(score)});
    prev_rp = 1;
    prev_lp = 1;
    tick;
    frame_tik = 1'b0;
    repeat (3) tick;
    right_btn = 1'b1;
    repeat (10) tick;
    chk("q_drain_edge", q.size(), 0);
    interval(0, 1);
    interval(1, 1);

    // Speed-up. A score change after a tick does not affect the interval already running.
    score = 8'd8;
    interval(1, 1);
    score = 8'd200;
    interval(1, 1);
    interval(1, 1);
    score = 8'd0;
    interval(1, 1);
    interval(1, 1);

    // Reset mid-interval, with partial frames counted and a press pending.
    frame(1'b0, 1, 1);
    frame(1'b0, 1, 1);
    frame(1'b0, 1, 1);
    press(1'b1, 1'b0, 12);
    reset = 1'b0;
    repeat (3) tick;
    chk("mrst_tik", int'(game_tik), 0);
    chk("mrst_rp", int'(right_P), 1);
    chk("mrst_lp", int'(left_P), 1);
    chk("mrst_div", int'(tick_div), 6);
    reset = 1'b1;
    tick;
    cur_div = 6;
    prev_rp = 1;
    prev_lp = 1;
    interval(1, 1);

    chk("final_q", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
